rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard that sits in front of the register file's single write port. It merges a single-cycle result stream (ALU) and a buffered long-latency result stream (load/mul/div) into one registered `RFWrite`/`rd`/`rd_WriteData` triple. It also tracks which destination registers have an outstanding long-latency write, so decode can stall on `rs0`..`rs2`.

## Interface
- `DEPTH`, 4: entries in the port-B FIFO; power of two, ≥2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  ALU result valid; always accepted.
- `a_rd`  in  `REG_LOG`  ALU destination register.
- `a_data`  in  `WORD`  ALU result.
- `b_valid`  in  1  long-latency result valid.
- `b_ready`  out  1  FIFO can accept; a transfer occurs when `b_valid & b_ready` at posedge.
- `b_rd`  in  `REG_LOG`  long-latency destination.
- `b_data`  in  `WORD`  long-latency result.
- `iss_valid`  in  1  long-latency instruction issued this cycle.
- `iss_rd`  in  `REG_LOG`  its destination.
- `rs0`, `rs1`, `rs2`  in  `REG_LOG` each  decode source indices.
- `busy0`, `busy1`, `busy2`  out  1 each  combinational: source has a pending long-latency write.
- `RFWrite`  out  1  registered write enable to the RF.
- `rd`  out  `REG_LOG`  registered write index.
- `rd_WriteData`  out  `WORD`  registered write data.

## Operation
- Output register is loaded every posedge with the following priority:
  - `a_valid`: load A; FIFO does not pop.
  - else, FIFO non-empty: pop the head and load it.
  - else: `RFWrite`=0.
- An entry whose destination is r0 is consumed, i.e. accepted or popped, with `RFWrite`=0 for that slot. `rd`/`rd_WriteData` still update.
- FIFO:
  - `b_ready` = !full.
  - No push-through: B data always passes through the FIFO.
  - Push and pop in the same cycle are legal when neither full nor empty.
  - When full, a pop frees a slot but `b_ready` is not updated combinationally in that same cycle. `b_ready` rises the cycle after the pop.
  - Pointers wrap modulo `DEPTH`.
  - Count is `log2(DEPTH)+1` bits.
  - Entries leave in strict arrival order.
- Scoreboard: 32-bit `busy` vector.
  - `iss_valid` sets `busy[iss_rd]`; r0 is never set.
  - A FIFO pop clears `busy[head.rd]`.
  - If a set and a clear hit the same index at the same edge, the set wins.
  - `busyN` = `busy[rsN]`; `busyN` is 0 when `rsN`=0.
- Illegal stimulus, flagged by a simulation-only assertion:
  - `iss_valid` to an index that is already busy.
  - `a_valid` to a busy index.

## Timing
- Reset values:
  - `RFWrite`=0, `rd`=0, `rd_WriteData`=0.
  - FIFO empty, so `b_ready`=1.
  - `busy`=0, so all `busyN`=0.
- Reset applied mid-operation discards all FIFO contents and pending busy bits in the same edge.
- A latency: `a_valid` sampled at edge N → `RFWrite` high during cycle N..N+1. The RF captures the write on the following negedge.
- B latency: accepted at edge N → earliest pop at edge N+1 → written during cycle N+1..N+2. Each cycle `a_valid` is high delays the pop by one cycle.
- Busy clear occurs at the pop edge. The RF completes the write at the negedge of that same output cycle, so a decode read sampled at the next posedge sees the new value.
- Throughput: one RF write per cycle.
- If A is valid every cycle, B starves; there is no fairness guarantee.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined: scoreboard and `busy0..2` logic as described above.
- `RF_WB_SCOREBOARD_EN` undefined:
  - No `busy` register.
  - `busy0..2` tied to 0.
  - `iss_valid`/`iss_rd` ignored.
  - Assertions removed.
  - Arbitration and FIFO behaviour are identical in both builds.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs → `RFWrite`=0, `rd`=0, `rd_WriteData`=0, `b_ready`=1, `busy0..2`=0.
- A path: `a_valid`=1, `a_rd`=5, `a_data`=0x00001234 at edge N → cycle after N: `RFWrite`=1, `rd`=5, data 0x1234; `RFWrite`=0 the following cycle.
- Contention: B push `rd`=7, data 0xAAAA5555 at N; A valid at N+1 and N+2 with `rd`=3, data 1 and 2 → writes appear in order (3,1), (3,2), (7,0xAAAA5555) on consecutive cycles after N+1, N+2, N+3.
- Full/wrap: hold `a_valid`=1 and push 5 B entries (rd 8..12) → `b_ready`=0 after the 4th; release A → rd 8,9,10,11 written in order; `b_ready`=1 the cycle after the first pop; the 5th entry (12) is written last. Repeat twice to exercise pointer wrap.
- Scoreboard: `iss_valid`, `iss_rd`=9 at N → `busy0`=1 with `rs0`=9 from N; B write to r9 popped at edge M → `busy0`=0 after M. Same-edge issue to r9 and pop of r9 → `busy` stays 1.
- r0: `a_rd`=0 and B `rd`=0 → `RFWrite` never asserts; `iss_rd`=0 → `busy0`=0 with `rs0`=0. Build without `RF_WB_SCOREBOARD_EN` → `busy0..2` stay 0 throughout.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the ALU stream (A) and the buffered long-latency stream (B) onto the single RF write port;
// optional pending-write scoreboard for decode stalls is built when RF_WB_SCOREBOARD_EN is defined.
// Latency: A or B-FIFO head -> registered RFWrite/rd/rd_WriteData in one cycle, A has priority.
// Backpressure: A never stalls; b_ready = FIFO not full from the registered count (re-opens the cycle after a pop).

module rf_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

module rf_wb_arbiter #(
    parameter int DEPTH   = 4,
    parameter int REG_LOG = 5,
    parameter int WORD    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    input  logic [REG_LOG-1:0] a_rd,
    input  logic [WORD-1:0]    a_data,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [REG_LOG-1:0] b_rd,
    input  logic [WORD-1:0]    b_data,
    input  logic               iss_valid,
    input  logic [REG_LOG-1:0] iss_rd,
    input  logic [REG_LOG-1:0] rs0,
    input  logic [REG_LOG-1:0] rs1,
    input  logic [REG_LOG-1:0] rs2,
    output logic               busy0,
    output logic               busy1,
    output logic               busy2,
    output logic               RFWrite,
    output logic [REG_LOG-1:0] rd,
    output logic [WORD-1:0]    rd_WriteData
);
    typedef struct packed {
        logic [REG_LOG-1:0] rd;
        logic [WORD-1:0]    data;
    } wb_ent_t;

    wb_ent_t push_ent;
    wb_ent_t head_ent;
    logic    full;
    logic    empty;
    logic    b_push;
    logic    b_pop;

    assign b_ready  = !full;
    assign b_push   = b_valid && !full;
    assign b_pop    = !a_valid && !empty;
    assign push_ent = {b_rd, b_data};

    rf_wb_fifo #(
        .WIDTH ($bits(wb_ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (b_push),
        .push_dat (push_ent),
        .pop      (b_pop),
        .head_dat (head_ent),
        .full     (full),
        .empty    (empty)
    );

    // r0 entries still occupy a slot and update rd/rd_WriteData, but never write.
    always_ff @(posedge clk) begin
        if (rst) begin
            RFWrite      <= 1'b0;
            rd           <= '0;
            rd_WriteData <= '0;
        end else if (a_valid) begin
            RFWrite      <= (a_rd != '0);
            rd           <= a_rd;
            rd_WriteData <= a_data;
        end else if (b_pop) begin
            RFWrite      <= (head_ent.rd != '0);
            rd           <= head_ent.rd;
            rd_WriteData <= head_ent.data;
        end else begin
            RFWrite      <= 1'b0;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    localparam int NREG = 1 << REG_LOG;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid && iss_rd != '0) busy_set[iss_rd] = 1'b1;
        if (b_pop)                     busy_clr[head_ent.rd] = 1'b1;
    end

    // Set is applied after clear so a same-edge issue to the popped index stays busy.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~busy_clr) | busy_set;
    end

    assign busy0 = (rs0 != '0) && busy[rs0];
    assign busy1 = (rs1 != '0) && busy[rs1];
    assign busy2 = (rs2 != '0) && busy[rs2];

    a_iss_not_busy: assert property (@(posedge clk) disable iff (rst)
        (iss_valid && iss_rd != '0) |-> !busy[iss_rd]);
    a_alu_not_busy: assert property (@(posedge clk) disable iff (rst)
        (a_valid && a_rd != '0) |-> !busy[a_rd]);
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, rs0, rs1, rs2};
    assign busy0 = 1'b0;
    assign busy1 = 1'b0;
    assign busy2 = 1'b0;
`endif
endmodule
